// File: rtl/simon_pkg.sv
// Shared Simon32/64 constants, state encoding and word helpers for the
// encrypt and decrypt cores.
package simon_pkg;

    localparam logic [15:0] SIMON_C = 16'hFFFC;
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

    typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, DONE} state_t;

    function automatic logic [15:0] rotl(input logic [15:0] v, input logic [3:0] j);
        logic [31:0] t;
        t = {v, v} << j;
        return t[31:16];
    endfunction

    function automatic logic [15:0] rotr(input logic [15:0] v, input logic [3:0] j);
        logic [31:0] t;
        t = {v, v} >> j;
        return t[15:0];
    endfunction

    function automatic logic [15:0] f(input logic [15:0] v);
        return (rotl(v, 4'd1) & rotl(v, 4'd8)) ^ rotl(v, 4'd2);
    endfunction

    // z(i) is read MSB-first from the Z0 literal
    function automatic logic zbit(input logic [5:0] i);
        logic [5:0] idx;
        idx = 6'd61 - i;
        return Z0[idx];
    endfunction

endpackage

// File: rtl/simon_key_step.sv
// One Simon32/64 key-schedule step over a 4-word window {w3,w2,w1,w0};
// bwd=0 produces k[i+4] from {k[i+3..i]}, bwd=1 produces k[i] from {k[i+4..i+1]}.
module simon_key_step
    import simon_pkg::*;
(
    input  logic [63:0] win,
    input  logic        z,
    input  logic        bwd,
    output logic [15:0] k_new
);

    logic [15:0] hi, lo, base, t;

    // Both directions share the k[i+3]/k[i+1] mix; only the window slots move
    always_comb begin
        hi    = bwd ? win[47:32] : win[63:48];
        lo    = bwd ? win[15:0]  : win[31:16];
        base  = bwd ? win[63:48] : win[15:0];
        t     = rotr(hi, 4'd3) ^ lo;
        k_new = SIMON_C ^ {15'd0, z} ^ base ^ t ^ rotr(t, 4'd1);
    end

endmodule

// File: rtl/simon32_64_dec.sv
// Iterative Simon32/64 decryptor: expand the key forward, then run the inverse
// rounds while walking the key window backward. SIMON_DEC_KEYCACHE_EN adds a last-key cache.
module simon32_64_dec
    import simon_pkg::*;
#(
    parameter int ROUNDS = 32,
    parameter int WORD   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*WORD-1:0] ciphertext,
    input  logic [4*WORD-1:0] key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*WORD-1:0] plaintext
);

    localparam logic [4:0] LAST_R   = 5'(ROUNDS - 1);
    localparam logic [4:0] EXP_LAST = 5'(ROUNDS - 5);

    state_t           state, state_nxt;
    logic [4:0]       cnt;
    logic [3:0][15:0] win, win_load;
    logic [15:0]      x, y, k_new, rk;
    logic [5:0]       zidx;
    logic             accept, hit;

    assign accept = in_valid & in_ready;
    assign zidx   = (state == EXPAND) ? {1'b0, cnt} : {1'b0, cnt} - 6'd4;
    // Below r=4 the window is frozen at {k3,k2,k1,k0}, so pick the key by index
    assign rk     = (cnt < 5'd4) ? win[cnt[1:0]] : win[3];

    simon_key_step u_key_step (
        .win   (win),
        .z     (zbit(zidx)),
        .bwd   (state == DECRYPT),
        .k_new (k_new)
    );

`ifdef SIMON_DEC_KEYCACHE_EN
    logic [63:0]      cache_key;
    logic [3:0][15:0] cache_win;
    logic             cache_vld;

    assign hit      = cache_vld && (key == cache_key);
    assign win_load = hit ? cache_win : key;

    // Key is captured at accept; the window becomes valid once EXPAND completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cache_key <= '0;
            cache_win <= '0;
            cache_vld <= 1'b0;
        end else if (accept && !hit) begin
            cache_key <= key;
            cache_vld <= 1'b0;
        end else if (state == EXPAND && cnt == EXP_LAST) begin
            cache_win <= {k_new, win[3:1]};
            cache_vld <= 1'b1;
        end
    end
`else
    assign hit      = 1'b0;
    assign win_load = key;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = hit ? DECRYPT : EXPAND;
            EXPAND:  if (cnt == EXP_LAST) state_nxt = DECRYPT;
            DECRYPT: if (cnt == 5'd0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            win <= '0;
            x   <= '0;
            y   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    x   <= ciphertext[31:16];
                    y   <= ciphertext[15:0];
                    win <= win_load;
                    cnt <= hit ? LAST_R : 5'd0;
                end
                EXPAND: begin
                    win <= {k_new, win[3:1]};
                    cnt <= (cnt == EXP_LAST) ? LAST_R : cnt + 5'd1;
                end
                DECRYPT: begin
                    x <= y;
                    y <= x ^ f(y) ^ rk;
                    if (cnt >= 5'd4) win <= {win[2:0], k_new};
                    if (cnt != 5'd0) cnt <= cnt - 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign plaintext = {x, y};

endmodule

// File: tb/tb_simon32_64_dec.sv
// Randomised bench for simon32_64_dec against an array-based Simon32/64 model.
module tb_simon32_64_dec;

    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [63:0] K1 = 64'h1918111009080100;
    localparam logic [31:0] C1 = 32'hC69BE9BB;
    localparam logic [31:0] P1 = 32'h65656877;
`ifdef SIMON_DEC_KEYCACHE_EN
    localparam int HIT_LAT = 32;
`else
    localparam int HIT_LAT = 60;
`endif

    logic        clk_tb = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] ciphertext, plaintext;
    logic [63:0] key;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk_tb = ~clk_tb;

    simon32_64_dec dut (
        .clk        (clk_tb),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext)
    );

    function automatic logic [15:0] rol(input logic [15:0] v, input int j);
        return 16'((v << j) | (v >> (16 - j)));
    endfunction

    function automatic logic [15:0] ror(input logic [15:0] v, input int j);
        return rol(v, 16 - j);
    endfunction

    function automatic logic [15:0] fr(input logic [15:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    // Full key schedule into an array, then straight-line rounds either way
    function automatic logic [31:0] ref_crypt(input logic [31:0] blk, input logic [63:0] k, input bit dec);
        logic [15:0] ks[32];
        logic [15:0] x, y, t;
        for (int i = 0; i < 4; i++) ks[i] = k[16*i +: 16];
        for (int i = 0; i < 28; i++) begin
            t = ror(ks[i+3], 3) ^ ks[i+1];
            t = t ^ ror(t, 1);
            ks[i+4] = 16'hFFFC ^ 16'(Z0[61-i]) ^ ks[i] ^ t;
        end
        x = blk[31:16];
        y = blk[15:0];
        for (int i = 0; i < 32; i++) begin
            if (!dec) begin t = x; x = y ^ fr(x) ^ ks[i]; y = t; end
            else      begin t = y; y = x ^ fr(y) ^ ks[31-i]; x = t; end
        end
        return {x, y};
    endfunction

    task automatic wait_accept(output bit acc);
        int w = 0;
        do begin
            acc = in_ready;
            @(posedge clk_tb); #1;
            w++;
        end while (!acc && w < 200);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk_tb); #1;
            lat++;
        end
    endtask

    task automatic run_block(input logic [31:0] ct, input logic [63:0] k,
                             output logic [31:0] pt, output int lat, output bit ok);
        bit acc;
        in_valid = 1'b1; ciphertext = ct; key = k;
        wait_accept(acc);
        wait_valid(lat);
        pt = plaintext;
        ok = acc && out_valid;
        out_ready = 1'b1;
        @(posedge clk_tb); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ciphertext = '0; key = '0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_tests++; if (plaintext !== 32'h0) begin n_fail++; $display("FAIL reset_plaintext got=%h exp=0", plaintext); end
        repeat (2) @(posedge clk_tb);
        #1 reset = 1'b1;
        @(posedge clk_tb); #1;
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset got=%b%b exp=10", in_ready, out_valid);
        end
    endtask

    task automatic test_known_vector();
        logic [31:0] pt; int lat; bit ok;
        run_block(C1, K1, pt, lat, ok);
        n_tests++; if (!ok || pt !== P1) begin n_fail++; $display("FAIL kat_pt got=%h ok=%b exp=%h", pt, ok, P1); end
        n_tests++; if (lat != 60) begin n_fail++; $display("FAIL kat_latency got=%0d exp=60", lat); end
    endtask

    task automatic test_random_ct();
        logic [31:0] pt, ct, exp; logic [63:0] k; int lat; bit ok;
        for (int v = 0; v < 6; v++) begin
            ct = $urandom; k = {$urandom, $urandom};
            exp = ref_crypt(ct, k, 1'b1);
            run_block(ct, k, pt, lat, ok);
            n_tests++; if (!ok || pt !== exp || lat != 60) begin
                n_fail++; $display("FAIL random_ct[%0d] got=%h lat=%0d exp=%h lat=60", v, pt, lat, exp);
            end
        end
    endtask

    task automatic test_hold_done();
        logic [31:0] p, p2, pt0, pt; logic [63:0] k, k2; int lat; bit acc, ok;
        p = $urandom; k = {$urandom, $urandom}; p2 = $urandom; k2 = {$urandom, $urandom};
        in_valid = 1'b1; ciphertext = ref_crypt(p, k, 1'b0); key = k;
        wait_accept(acc);
        wait_valid(lat);
        pt0 = plaintext;
        n_tests++; if (!acc || !out_valid || pt0 !== p) begin
            n_fail++; $display("FAIL hold_first_pt got=%h exp=%h", pt0, p);
        end
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1; ciphertext = ref_crypt(p2, k2, 1'b0); key = k2;
            @(posedge clk_tb); #1;
            n_tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || plaintext !== pt0) begin
                n_fail++; $display("FAIL hold_stable[%0d] got=%b%b %h exp=10 %h", c, out_valid, in_ready, plaintext, pt0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk_tb); #1;
        out_ready = 1'b0;
        run_block(ref_crypt(p2, k2, 1'b0), k2, pt, lat, ok);
        n_tests++; if (!ok || pt !== p2 || lat != 60) begin
            n_fail++; $display("FAIL hold_second got=%h lat=%0d exp=%h lat=60", pt, lat, p2);
        end
    endtask

    task automatic test_ready_early();
        logic [31:0] p, pt; logic [63:0] k; int lat, hi_cycles; bit acc;
        p = $urandom; k = {$urandom, $urandom};
        out_ready = 1'b1;
        in_valid = 1'b1; ciphertext = ref_crypt(p, k, 1'b0); key = k;
        wait_accept(acc);
        wait_valid(lat);
        pt = plaintext;
        hi_cycles = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) hi_cycles++;
            @(posedge clk_tb); #1;
        end
        out_ready = 1'b0;
        n_tests++; if (!acc || pt !== p || lat != 60) begin
            n_fail++; $display("FAIL early_ready_pt got=%h lat=%0d exp=%h lat=60", pt, lat, p);
        end
        n_tests++; if (hi_cycles != 1) begin
            n_fail++; $display("FAIL early_ready_width got=%0d exp=1", hi_cycles);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_q[$];
        logic [31:0] p, hold; logic [63:0] k; int lat, n_out; bit acc;
        n_out = 0;
        for (int v = 0; v < 150; v++) begin
            p = $urandom; k = {$urandom, $urandom};
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0; out_ready = 1'($urandom_range(0, 1));
                @(posedge clk_tb); #1;
            end
            in_valid = 1'b1; ciphertext = ref_crypt(p, k, 1'b0); key = k;
            wait_accept(acc);
            if (acc) exp_q.push_back(p);
            lat = 0;
            while (!out_valid && lat < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk_tb); #1;
                lat++;
            end
            out_ready = 1'b0;
            hold = plaintext;
            repeat ($urandom_range(0, 4)) begin
                @(posedge clk_tb); #1;
                n_tests++; if (plaintext !== hold || out_valid !== 1'b1) begin
                    n_fail++; $display("FAIL stream_stall[%0d] got=%h exp=%h", v, plaintext, hold);
                end
            end
            if (out_valid) begin
                n_out++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra[%0d] got=%h exp=none", v, plaintext);
                end else if (plaintext !== exp_q[0] || lat != 60) begin
                    n_fail++; $display("FAIL stream_pt[%0d] got=%h lat=%0d exp=%h lat=60", v, plaintext, lat, exp_q[0]);
                    void'(exp_q.pop_front());
                end else void'(exp_q.pop_front());
                out_ready = 1'b1;
                @(posedge clk_tb); #1;
                out_ready = 1'b0;
            end
        end
        n_tests++; if (n_out != 150 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL stream_count got=%0d left=%0d exp=150 left=0", n_out, exp_q.size());
        end
    endtask

    task automatic test_abort();
        logic [31:0] pt; int lat, seen; bit acc, ok;
        in_valid = 1'b1; ciphertext = C1; key = K1;
        wait_accept(acc);
        repeat (49) begin @(posedge clk_tb); #1; end
        reset = 1'b0;
        #1;
        n_tests++; if (!acc || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_immediate got=%b%b exp=01", out_valid, in_ready);
        end
        @(posedge clk_tb); #1;
        reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 70; c++) begin
            if (out_valid) seen++;
            @(posedge clk_tb); #1;
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_output got=%0d exp=0", seen); end
        run_block(C1, K1, pt, lat, ok);
        n_tests++; if (!ok || pt !== P1 || lat != 60) begin
            n_fail++; $display("FAIL abort_rerun got=%h lat=%0d exp=%h lat=60", pt, lat, P1);
        end
    endtask

    task automatic test_key_cache();
        logic [31:0] p, pt; logic [63:0] k; int lat; bit ok;
        p = $urandom; k = {$urandom, $urandom};
        run_block(ref_crypt(p, k, 1'b0), k, pt, lat, ok);
        n_tests++; if (!ok || pt !== p || lat != 60) begin
            n_fail++; $display("FAIL cache_other got=%h lat=%0d exp=%h lat=60", pt, lat, p);
        end
        run_block(C1, K1, pt, lat, ok);
        n_tests++; if (!ok || pt !== P1 || lat != 60) begin
            n_fail++; $display("FAIL cache_fill got=%h lat=%0d exp=%h lat=60", pt, lat, P1);
        end
        run_block(C1, K1, pt, lat, ok);
        n_tests++; if (!ok || pt !== P1 || lat != HIT_LAT) begin
            n_fail++; $display("FAIL cache_repeat got=%h lat=%0d exp=%h lat=%0d", pt, lat, P1, HIT_LAT);
        end
        p = $urandom; k = {$urandom, $urandom};
        run_block(ref_crypt(p, k, 1'b0), k, pt, lat, ok);
        n_tests++; if (!ok || pt !== p || lat != 60) begin
            n_fail++; $display("FAIL cache_newkey got=%h lat=%0d exp=%h lat=60", pt, lat, p);
        end
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_random_ct();
        test_hold_done();
        test_ready_early();
        test_stream();
        test_abort();
        test_key_cache();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
